fft_band_reader: RTL and testbench
==================================

# fft_band_reader

Consumer at the output end of the 512-point pipelined FFT. Takes the FFT's bit-reversed-corrected output stream (`i_sample` plus `i_sync` frame marker, advanced by `i_ce`) and computes |X|² per bin. It accumulates positive-frequency bins 1..255 into 8 octave bands and presents each completed frame's band levels as an 8-beat valid/ready stream to the VU-meter display logic.

## Interface
- `IWIDTH`, default 8: bits per real/imag component; must match FFT `OWIDTH`.
- `LGFFT`, default 9: log2 FFT size. Derived values:
  - NBANDS = LGFFT-1 = 8.
  - ACCW = 2*IWIDTH+LGFFT-2 = 23.
- `i_clk`, input, 1 bit: clock.
- `i_reset`, input, 1 bit: synchronous reset, active-high.
- `i_ce`, input, 1 bit: sample enable, same strobe that drives the FFT.
- `i_sample`, input, 2*IWIDTH bits: {real, imag}, two's complement, real in the high half.
- `i_sync`, input, 1 bit: marks bin 0 of a frame; only meaningful while `i_ce` is high.
- `o_band_valid`, output, 1 bit: band beat valid.
- `i_band_ready`, input, 1 bit: downstream accepts the beat.
- `o_band_idx`, output, 3 bits: band number 0..7.
- `o_band_level`, output, 2*IWIDTH bits: mean |X|² over the band's bins, unsigned.
- `o_overrun`, output, 1 bit: one-cycle pulse when a completed frame is dropped.

## Operation
- Arming: `armed` clears on reset and sets on the first `i_ce && i_sync`. Samples before that are ignored.
- Bin counter (9 bits), updated on `i_ce` only:
  - If `i_sync`, the bin is 0.
  - Otherwise the bin is the previous bin + 1, wrapping 511→0.
- Magnitude pipeline, advanced only on `i_ce`. It carries a valid bit and the bin number alongside the data.
  - Stage A: re², im², registered, each 2*IWIDTH-1 bits unsigned.
  - Stage B: magsq = re²+im², 2*IWIDTH bits unsigned. Maximum is 32768 at (-128,-128); no overflow.
- Accumulate step, on `i_ce` with stage B valid:
  - bin 0: clear all 8 accumulators. Bin 0 is not added. This also discards any partial frame when `i_sync` arrives early.
  - bins 1..255: `acc[b] += magsq`, where b is the index of the MSB of the bin, so band b covers bins 2^b..2^(b+1)-1. Accumulators are ACCW bits and cannot overflow.
  - bins 256..511: ignored.
  - bin 255 is the commit point. The commit value for band 7 includes bin 255's magsq.
- Output FSM:
  - IDLE: `o_band_valid`=0.
  - SEND: `o_band_valid`=1, `o_band_idx`=k, `o_band_level`=shadow[k]>>k. The shift is exact; the maximum result is 32768.
- Transitions:
  - IDLE + commit → load shadow, k=0, SEND.
  - SEND + valid&ready with k<7 → k+1.
  - SEND + valid&ready with k=7 → IDLE.
  - SEND + commit, no final accept → frame dropped. Shadow is unchanged and `o_overrun` pulses.
  - SEND + commit in the same cycle as the k=7 accept → new frame loaded, k=0, stay in SEND. No overrun.
- Stability: while valid is high and ready is low, idx and level hold stable.

## Timing
- Reset values: `o_band_valid`=0, `o_band_idx`=0, `o_band_level`=0, `o_overrun`=0. Reset also clears the FSM (IDLE), accumulators, shadow, pipeline valids and `armed`.
- Reset mid-frame or mid-SEND: everything in progress is discarded. Nothing is output until a new `i_sync` arrives followed by bin 255.
- Commit timing: the commit edge is the 3rd `i_ce` edge counting the edge that samples bin 255.
  - With continuous `i_ce`, bin 255 is sampled at edge t, commit is at edge t+2, and `o_band_valid` is first high in cycle t+3.
- `i_ce` gaps stretch the pipeline. They have no effect on the output FSM, which runs every clock.
- With `i_band_ready` held at 1, the 8 beats occupy 8 consecutive cycles.
- `o_overrun`: high exactly one cycle after the dropped commit edge.

## Structure
- Package `fft_band_pkg` holds:
  - constants NBANDS, ACCW and band-index width;
  - the MSB-position function that maps bin to band;
  - FSM state encodings IDLE and SEND.
- Sub-module `fft_band_magsq`: the two-stage, `i_ce`-gated squaring pipeline, passing valid and bin through.
- The top level holds the bin counter, accumulators, shadow registers and output FSM.

## Test plan
- Reset check: assert `i_reset` mid-SEND → next cycle all outputs are 0. Feeding bins up to 255 without a new `i_sync` produces no valid.
- Single tone: a frame with bin 5=(10,-4) and all other bins 0, ready=1.
  - Beats idx 0..7 arrive in 8 consecutive cycles.
  - idx2 level = 116>>2 = 29; all other levels are 0.
  - First valid appears 3 cycles after bin 255.
- Full scale: all bins = (-128,-128) → every band level = 32768. Bins 0 and 256..511 set to other values do not change the result.
- Backpressure: ready=0 for 5 cycles while idx 3 is presented → idx 3 and its level stay stable; the sequence then resumes at idx 4.
- Overrun: ready=0 across two full frames → `o_overrun` is high for exactly one cycle at the second commit. The first frame's values are emitted when ready returns.
- Early resync plus `i_ce` gaps: `i_sync` at bin 100 with random 50% `i_ce` → the partial frame is discarded, and the band values match a reference model of the frame that follows.

Source files
------------

// File: rtl/fft_band_pkg.sv
// Shared constants, bin-to-band mapping and output FSM encoding for the FFT band reader.
package fft_band_pkg;
   localparam int NBANDS     = 8;
   localparam int BAND_IDX_W = 3;
   localparam int ACCW       = 23;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } band_state_t;

   // Position of the most significant set bit; band b spans bins 2^b .. 2^(b+1)-1.
   function automatic logic [BAND_IDX_W-1:0] bin_band(input logic [NBANDS-1:0] bin);
      logic [BAND_IDX_W-1:0] pos;
      pos = '0;
      for (int i = 0; i < NBANDS; i++) begin
         if (bin[i]) pos = BAND_IDX_W'(i);
      end
      return pos;
   endfunction
endpackage

// File: rtl/fft_band_magsq.sv
// Two-stage |X|^2 pipeline advanced by the FFT sample enable; valid and bin ride alongside.
module fft_band_magsq #(
   parameter int IWIDTH = 8,
   parameter int BINW   = 9
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_ce,
   input  logic                i_valid,
   input  logic [BINW-1:0]     i_bin,
   input  logic [2*IWIDTH-1:0] i_sample,
   output logic                o_valid,
   output logic [BINW-1:0]     o_bin,
   output logic [2*IWIDTH-1:0] o_magsq
);
   logic signed [2*IWIDTH-2:0] re_x;
   logic signed [2*IWIDTH-2:0] im_x;
   logic                       a_valid;
   logic [BINW-1:0]            a_bin;
   logic [2*IWIDTH-2:0]        a_re_sq;
   logic [2*IWIDTH-2:0]        a_im_sq;

   // Squares are computed at 2*IWIDTH-1 bits: (-2^(W-1))^2 = 2^(2W-2) still fits.
   assign re_x = (2*IWIDTH-1)'($signed(i_sample[2*IWIDTH-1:IWIDTH]));
   assign im_x = (2*IWIDTH-1)'($signed(i_sample[IWIDTH-1:0]));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         a_valid <= 1'b0;
         a_bin   <= '0;
         a_re_sq <= '0;
         a_im_sq <= '0;
         o_valid <= 1'b0;
         o_bin   <= '0;
         o_magsq <= '0;
      end else if (i_ce) begin
         a_valid <= i_valid;
         a_bin   <= i_bin;
         a_re_sq <= re_x * re_x;
         a_im_sq <= im_x * im_x;
         o_valid <= a_valid;
         o_bin   <= a_bin;
         o_magsq <= {1'b0, a_re_sq} + {1'b0, a_im_sq};
      end
   end
endmodule

// File: rtl/fft_band_reader.sv
// Octave-band power meter on the FFT output: accumulates |X|^2 of bins 1..255 into 8 bands
// and streams each completed frame's band means as 8 valid/ready beats.
module fft_band_reader
   import fft_band_pkg::*;
#(
   parameter int IWIDTH = 8,
   parameter int LGFFT  = 9
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_ce,
   input  logic [2*IWIDTH-1:0]   i_sample,
   input  logic                  i_sync,
   output logic                  o_band_valid,
   input  logic                  i_band_ready,
   output logic [BAND_IDX_W-1:0] o_band_idx,
   output logic [2*IWIDTH-1:0]   o_band_level,
   output logic                  o_overrun
);
   localparam int ACC_W = 2*IWIDTH + LGFFT - 2;
   localparam logic [LGFFT-1:0] COMMIT_BIN = {1'b0, {(LGFFT-1){1'b1}}};
   localparam logic [BAND_IDX_W-1:0] LAST_IDX = BAND_IDX_W'(NBANDS-1);

   logic                  armed;
   logic [LGFFT-1:0]      bin_q;
   logic [LGFFT-1:0]      cur_bin;
   logic                  b_valid;
   logic [LGFFT-1:0]      b_bin;
   logic [2*IWIDTH-1:0]   b_magsq;
   logic [BAND_IDX_W-1:0] band;
   logic [ACC_W-1:0]      acc      [NBANDS];
   logic [ACC_W-1:0]      acc_next [NBANDS];
   logic [ACC_W-1:0]      shadow   [NBANDS];
   logic                  commit;
   band_state_t           state;
   band_state_t           state_n;
   logic [BAND_IDX_W-1:0] k;
   logic [BAND_IDX_W-1:0] k_n;
   logic                  load;
   logic                  overrun_n;
   logic                  accept;

   assign cur_bin = i_sync ? '0 : bin_q + 1'b1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         armed <= 1'b0;
         bin_q <= '0;
      end else if (i_ce) begin
         bin_q <= cur_bin;
         if (i_sync) armed <= 1'b1;
      end
   end

   fft_band_magsq #(
      .IWIDTH (IWIDTH),
      .BINW   (LGFFT)
   ) u_magsq (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_ce     (i_ce),
      .i_valid  (armed | i_sync),
      .i_bin    (cur_bin),
      .i_sample (i_sample),
      .o_valid  (b_valid),
      .o_bin    (b_bin),
      .o_magsq  (b_magsq)
   );

   assign band = bin_band(b_bin[NBANDS-1:0]);

   // acc_next is also the commit value, so bin 255 lands in the shadow copy of band 7.
   always_comb begin
      commit = 1'b0;
      for (int b = 0; b < NBANDS; b++) acc_next[b] = acc[b];
      if (i_ce && b_valid) begin
         if (b_bin == '0) begin
            for (int b = 0; b < NBANDS; b++) acc_next[b] = '0;
         end else if (!b_bin[LGFFT-1]) begin
            for (int b = 0; b < NBANDS; b++) begin
               if (band == BAND_IDX_W'(b)) acc_next[b] = acc[b] + ACC_W'(b_magsq);
            end
            commit = (b_bin == COMMIT_BIN);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int b = 0; b < NBANDS; b++) begin
            acc[b]    <= '0;
            shadow[b] <= '0;
         end
      end else begin
         for (int b = 0; b < NBANDS; b++) begin
            acc[b] <= acc_next[b];
            if (load) shadow[b] <= acc_next[b];
         end
      end
   end

   // Handshake: a beat transfers on a clock edge where o_band_valid and i_band_ready are
   // both high; while valid waits for ready, o_band_idx and o_band_level hold stable.
   assign o_band_valid = (state == SEND);
   assign o_band_idx   = k;
   assign o_band_level = (2*IWIDTH)'(shadow[k] >> k);
   assign accept       = o_band_valid && i_band_ready;

   always_comb begin
      state_n   = state;
      k_n       = k;
      load      = 1'b0;
      overrun_n = 1'b0;
      case (state)
         IDLE: begin
            if (commit) begin
               load    = 1'b1;
               k_n     = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            if (accept) begin
               if (k == LAST_IDX) begin
                  k_n     = '0;
                  state_n = IDLE;
               end else begin
                  k_n = k + 1'b1;
               end
            end
            // A commit only wins if the last beat is leaving this very cycle.
            if (commit) begin
               if (accept && k == LAST_IDX) begin
                  load    = 1'b1;
                  k_n     = '0;
                  state_n = SEND;
               end else begin
                  overrun_n = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= IDLE;
         k         <= '0;
         o_overrun <= 1'b0;
      end else begin
         state     <= state_n;
         k         <= k_n;
         o_overrun <= overrun_n;
      end
   end
endmodule

// File: tb/tb_fft_band_reader.sv
// Directed self-checking bench for fft_band_reader: band beats are scored against an expected queue.
module tb_fft_band_reader;
   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_ce;
   logic [15:0] i_sample;
   logic        i_sync;
   logic        o_band_valid;
   logic        i_band_ready;
   logic [2:0]  o_band_idx;
   logic [15:0] o_band_level;
   logic        o_overrun;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int t255 = 0;
   int first_valid_cyc = -1;
   int ovr_count = 0;
   int ovr_cyc = 0;
   int valid_cycles = 0;
   int beat_cyc[$];
   logic [18:0] exp_q[$];
   logic signed [7:0] fr_re [512];
   logic signed [7:0] fr_im [512];

   fft_band_reader #(.IWIDTH(8), .LGFFT(9)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_ce         (i_ce),
      .i_sample     (i_sample),
      .i_sync       (i_sync),
      .o_band_valid (o_band_valid),
      .i_band_ready (i_band_ready),
      .o_band_idx   (o_band_idx),
      .o_band_level (o_band_level),
      .o_overrun    (o_overrun)
   );

   // clock / cycle counter
   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // scoreboard: every accepted beat is compared with the head of exp_q
   always @(negedge i_clk) begin
      logic [18:0] e;
      if (o_band_valid === 1'b1) begin
         valid_cycles++;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (o_overrun === 1'b1) begin
         ovr_count++;
         ovr_cyc = cyc;
      end
      if (o_band_valid === 1'b1 && i_band_ready === 1'b1) begin
         beat_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {13'd0, o_band_idx, o_band_level}, 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            check("beat", {13'd0, o_band_idx, o_band_level}, {13'd0, e});
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_bin(input logic [7:0] re, input logic [7:0] im, input logic sync,
                           input bit gaps);
      if (gaps) begin
         while ($urandom_range(1, 0) == 1) begin
            i_ce     = 1'b0;
            i_sync   = 1'b1;
            i_sample = 16'($urandom);
            tick();
         end
      end
      i_ce     = 1'b1;
      i_sync   = sync;
      i_sample = {re, im};
      tick();
      i_ce   = 1'b0;
      i_sync = 1'b0;
   endtask

   task automatic send_frame(input int nbins, input bit gaps);
      for (int i = 0; i < nbins; i++) begin
         send_bin(fr_re[i], fr_im[i], i == 0, gaps);
         if (i == 255) t255 = cyc;
      end
   endtask

   task automatic fill_const(input logic [7:0] re, input logic [7:0] im);
      for (int i = 0; i < 512; i++) begin
         fr_re[i] = re;
         fr_im[i] = im;
      end
   endtask

   // band b gets (b+1, 0) in every bin, so its mean power is (b+1)^2
   task automatic fill_ramp();
      fill_const(8'd0, 8'd0);
      for (int b = 0; b < 8; b++) begin
         for (int i = (1 << b); i < (2 << b); i++) fr_re[i] = 8'(b + 1);
      end
   endtask

   task automatic push_ramp();
      for (int b = 0; b < 8; b++) exp_q.push_back({3'(b), 16'((b + 1) * (b + 1))});
   endtask

   task automatic fill_random();
      for (int i = 0; i < 512; i++) begin
         fr_re[i] = 8'($urandom_range(255, 0));
         fr_im[i] = 8'($urandom_range(255, 0));
      end
   endtask

   // reference model: mean of re^2+im^2 over bins 2^b .. 2^(b+1)-1
   task automatic push_model();
      int sum;
      for (int b = 0; b < 8; b++) begin
         sum = 0;
         for (int i = (1 << b); i < (2 << b); i++)
            sum += int'(fr_re[i]) * int'(fr_re[i]) + int'(fr_im[i]) * int'(fr_im[i]);
         exp_q.push_back({3'(b), 16'(sum >> b)});
      end
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || o_band_valid) && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic stall_at_idx3();
      int n;
      n = 0;
      while (!(o_band_valid && o_band_idx == 3'd3) && n < 2000) begin
         tick();
         n++;
      end
      check("bp_reach_idx3", n < 2000, 1);
      i_band_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_valid", o_band_valid, 1);
         check("bp_hold_idx", o_band_idx, 3);
         check("bp_hold_level", o_band_level, 16);
      end
      i_band_ready = 1'b1;
      tick();
      check("bp_resume_idx", o_band_idx, 4);
   endtask

   initial begin
      i_reset      = 1'b1;
      i_ce         = 1'b0;
      i_sync       = 1'b0;
      i_sample     = '0;
      i_band_ready = 1'b0;
      repeat (3) tick();
      check("rst_valid", o_band_valid, 0);
      check("rst_idx", o_band_idx, 0);
      check("rst_level", o_band_level, 0);
      check("rst_overrun", o_overrun, 0);
      i_reset = 1'b0;
      tick();

      // single tone: bin 5 = (10,-4) -> 116 in band 2 -> 116>>2 = 29
      fill_const(8'd0, 8'd0);
      fr_re[5] = 8'sd10;
      fr_im[5] = -8'sd4;
      for (int b = 0; b < 8; b++) exp_q.push_back({3'(b), (b == 2) ? 16'd29 : 16'd0});
      i_band_ready = 1'b1;
      beat_cyc.delete();
      first_valid_cyc = -1;
      send_frame(512, 1'b0);
      wait_drain("tone");
      check("tone_beats", beat_cyc.size(), 8);
      if (beat_cyc.size() == 8) check("tone_consecutive", beat_cyc[7] - beat_cyc[0], 7);
      // valid is first seen in the cycle after the second edge following the bin-255 edge
      check("tone_latency", first_valid_cyc - t255, 2);

      // full scale, with bin 0 and upper half set to other values
      fill_const(8'h80, 8'h80);
      fr_re[0] = 8'sd5;
      fr_im[0] = 8'sd3;
      for (int i = 256; i < 512; i++) begin
         fr_re[i] = 8'sd7;
         fr_im[i] = -8'sd9;
      end
      for (int b = 0; b < 8; b++) exp_q.push_back({3'(b), 16'd32768});
      send_frame(512, 1'b0);
      wait_drain("full");

      // backpressure on idx 3
      fill_ramp();
      push_ramp();
      fork
         send_frame(512, 1'b0);
         stall_at_idx3();
      join
      wait_drain("bp");

      // overrun: two frames with ready low, first frame survives
      i_band_ready = 1'b0;
      ovr_count = 0;
      fill_ramp();
      push_ramp();
      send_frame(512, 1'b0);
      check("ovr_none_first", ovr_count, 0);
      fill_const(8'd2, 8'd0);
      send_frame(512, 1'b0);
      check("ovr_count", ovr_count, 1);
      check("ovr_cycle", ovr_cyc - t255, 2);
      i_band_ready = 1'b1;
      wait_drain("ovr");

      // early resync with random i_ce gaps
      fill_random();
      send_frame(100, 1'b1);
      fill_random();
      push_model();
      send_frame(512, 1'b1);
      wait_drain("resync");

      // reset while a frame is waiting in SEND
      i_band_ready = 1'b0;
      fill_ramp();
      push_ramp();
      send_frame(512, 1'b0);
      check("pre_rst_valid", o_band_valid, 1);
      i_reset = 1'b1;
      tick();
      check("midrst_valid", o_band_valid, 0);
      check("midrst_idx", o_band_idx, 0);
      check("midrst_level", o_band_level, 0);
      check("midrst_overrun", o_overrun, 0);
      i_reset = 1'b0;
      exp_q.delete();
      valid_cycles = 0;
      i_band_ready = 1'b1;
      for (int i = 1; i < 300; i++) send_bin(fr_re[i], fr_im[i], 1'b0, 1'b0);
      repeat (5) tick();
      check("rst_no_valid", valid_cycles, 0);
      check("ovr_total", ovr_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end
endmodule
